// File: rtl/pipeline_stall_ctrl_if.sv
// Purpose: hazard/stall bundle between the pipeline datapath and the stall controller.
// Ports (per modport):
//   master (pipeline side) drives the hazard inputs and clr_err, and reads the stall and flush
//     controls, the error flag and the counters.
//   slave (controller side) reads the hazard inputs and drives the controls, the error flag
//     and the counters.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs1_IfId;
  logic [4:0]       rs2_IfId;
  logic             use_rs1_IfId;
  logic             use_rs2_IfId;
  logic [4:0]       rd_IdEx;
  logic             mem_read_IdEx;
  logic             branch_taken_Ex;
  logic             dmem_req_ExMem;
  logic             dmem_ready;
  logic             clr_err;
  logic             stall_pc;
  logic             stall_IfId;
  logic             stall_IdEx;
  logic             stall_ExMem;
  logic             flush_IfId;
  logic             bubble_IdEx;
  logic             bubble_MemWB;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] load_use_count;

  modport master (
    output rs1_IfId, rs2_IfId, use_rs1_IfId, use_rs2_IfId, rd_IdEx, mem_read_IdEx,
           branch_taken_Ex, dmem_req_ExMem, dmem_ready, clr_err,
    input  stall_pc, stall_IfId, stall_IdEx, stall_ExMem, flush_IfId, bubble_IdEx,
           bubble_MemWB, mem_timeout, stall_cycles, flush_count, load_use_count
  );

  modport slave (
    input  rs1_IfId, rs2_IfId, use_rs1_IfId, use_rs2_IfId, rd_IdEx, mem_read_IdEx,
           branch_taken_Ex, dmem_req_ExMem, dmem_ready, clr_err,
    output stall_pc, stall_IfId, stall_IdEx, stall_ExMem, flush_IfId, bubble_IdEx,
           bubble_MemWB, mem_timeout, stall_cycles, flush_count, load_use_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Purpose: stall/flush controller for the 5-stage pipeline. It covers the hazards that
//   forwarding cannot resolve: load-use, taken-branch redirect and data-memory wait states.
//   It also runs a memory-wait timeout monitor and keeps saturating performance counters.
// Ports:
//   clk   - system clock; all state changes on the rising edge
//   rst_n - asynchronous active-low reset; it also forces the control outputs to 0
//   bus   - slave side of pipeline_stall_ctrl_if:
//           hazard inputs in; hold, flush and bubble controls, timeout flag and counters out
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] load_use_count;

  logic mem_stall_c;
  logic load_use_c;
  logic timeout_set_c;
  logic stall_pc_c, stall_IfId_c, stall_IdEx_c, stall_ExMem_c;
  logic flush_IfId_c, bubble_IdEx_c, bubble_MemWB_c;
  logic load_use_taken_c;

  // Hazard detection
  assign mem_stall_c = bus.dmem_req_ExMem & ~bus.dmem_ready;
  assign load_use_c  = bus.mem_read_IdEx & (bus.rd_IdEx != 5'd0) &
                       ((bus.use_rs1_IfId & (bus.rs1_IfId == bus.rd_IdEx)) |
                        (bus.use_rs2_IfId & (bus.rs2_IfId == bus.rd_IdEx)));

  // The timeout keeps asserting while the saturated wait persists, so it overrides clr_err
  assign timeout_set_c = (state == MEM_WAIT) & mem_stall_c &
                         (wait_cnt == WC_W'(MEM_TIMEOUT));

  // Priority-encoded controls: memory wait > branch redirect > load-use; gated by rst_n
  always_comb begin
    stall_pc_c       = 1'b0;
    stall_IfId_c     = 1'b0;
    stall_IdEx_c     = 1'b0;
    stall_ExMem_c    = 1'b0;
    flush_IfId_c     = 1'b0;
    bubble_IdEx_c    = 1'b0;
    bubble_MemWB_c   = 1'b0;
    load_use_taken_c = 1'b0;
    if (rst_n) begin
      if (mem_stall_c) begin
        // EX is frozen, so a pending branch is re-presented on the release cycle
        stall_pc_c     = 1'b1;
        stall_IfId_c   = 1'b1;
        stall_IdEx_c   = 1'b1;
        stall_ExMem_c  = 1'b1;
        bubble_MemWB_c = 1'b1;
      end else if (bus.branch_taken_Ex) begin
        // Any load-use in ID is on the wrong path and gets flushed
        flush_IfId_c  = 1'b1;
        bubble_IdEx_c = 1'b1;
      end else if (load_use_c) begin
        // The bubble clears mem_read_IdEx, so the stall lasts exactly one cycle
        stall_pc_c       = 1'b1;
        stall_IfId_c     = 1'b1;
        bubble_IdEx_c    = 1'b1;
        load_use_taken_c = 1'b1;
      end
    end
  end

  // Wait-state FSM, timeout flag and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      wait_cnt       <= '0;
      mem_timeout    <= 1'b0;
      stall_cycles   <= '0;
      flush_count    <= '0;
      load_use_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall_c) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          // A completed access or a dropped request both release the pipeline
          if (!mem_stall_c) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WC_W'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase

      if (timeout_set_c)    mem_timeout <= 1'b1;
      else if (bus.clr_err) mem_timeout <= 1'b0;

      if (stall_pc_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_IfId_c && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
      if (load_use_taken_c && (load_use_count != '1))
        load_use_count <= load_use_count + CNT_W'(1);
    end
  end

  assign bus.stall_pc       = stall_pc_c;
  assign bus.stall_IfId     = stall_IfId_c;
  assign bus.stall_IdEx     = stall_IdEx_c;
  assign bus.stall_ExMem    = stall_ExMem_c;
  assign bus.flush_IfId     = flush_IfId_c;
  assign bus.bubble_IdEx    = bubble_IdEx_c;
  assign bus.bubble_MemWB   = bubble_MemWB_c;
  assign bus.mem_timeout    = mem_timeout;
  assign bus.stall_cycles   = stall_cycles;
  assign bus.flush_count    = flush_count;
  assign bus.load_use_count = load_use_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Purpose: self-checking bench for pipeline_stall_ctrl. It applies a vector table plus
//   multi-cycle sequences: memory wait, timeout, branch held across a wait, and reset mid-wait.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 4;

  // Expected control word: {stall_pc, stall_IfId, stall_IdEx, stall_ExMem,
  //                         flush_IfId, bubble_IdEx, bubble_MemWB}
  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_LU   = 7'b1100010;
  localparam logic [6:0] E_MEM  = 7'b1111001;
  localparam logic [6:0] E_BR   = 7'b0000110;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  sb_t  sb_q[$];
  vec_t tbl[12];

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic mr, logic br, logic req, logic rdy,
                              logic [6:0] exp);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] ctrl_out();
    return {bus.stall_pc, bus.stall_IfId, bus.stall_IdEx, bus.stall_ExMem,
            bus.flush_IfId, bus.bubble_IdEx, bus.bubble_MemWB};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs and record the expected controls
  task automatic apply(vec_t v);
    bus.rs1_IfId        = v.rs1;
    bus.rs2_IfId        = v.rs2;
    bus.use_rs1_IfId    = v.u1;
    bus.use_rs2_IfId    = v.u2;
    bus.rd_IdEx         = v.rd;
    bus.mem_read_IdEx   = v.mr;
    bus.branch_taken_Ex = v.br;
    bus.dmem_req_ExMem  = v.req;
    bus.dmem_ready      = v.rdy;
    sb_q.push_back('{v.name, v.exp});
  endtask

  // Pop the oldest expectation and compare it with the settled outputs
  task automatic sample();
    sb_t e;
    #2;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, 32'(ctrl_out()), 32'(e.exp));
    end
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    apply(v);
    sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.clr_err = 1'b0;
    apply(mk("rst_gate", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, E_NONE));
    sample();
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush_count", 32'(bus.flush_count), 32'd0);
    chk("rst_load_use_count", 32'(bus.load_use_count), 32'd0);
    chk("rst_mem_timeout", 32'(bus.mem_timeout), 32'd0);
    @(negedge clk);
    apply(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
    #1 rst_n = 1'b1;
    sample();
  endtask

  initial begin
    int exp_stall, exp_flush, exp_lu;
    vec_t idle, memw, memw_br, rel_br;

    rst_n = 1'b0;
    bus.clr_err = 1'b0;
    idle = mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);

    //         name          rs1    rs2    u1    u2    rd     mr    br    req   rdy   exp
    tbl[0]  = mk("all_zero",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[1]  = mk("lu_rs2",    5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    tbl[2]  = mk("rd_zero",   5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[3]  = mk("rs1_unused",5'd7,  5'd2,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[4]  = mk("not_load",  5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[5]  = mk("lu_rs1",    5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    tbl[6]  = mk("br_and_lu", 5'd6,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 1'b0, 1'b0, E_BR);
    tbl[7]  = mk("br_only",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, E_BR);
    tbl[8]  = mk("zero_wait", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, E_NONE);
    tbl[9]  = mk("mem_all",   5'd4,  5'd0,  1'b1, 1'b0, 5'd4,  1'b1, 1'b1, 1'b1, 1'b0, E_MEM);
    tbl[10] = mk("req_drop",  5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    tbl[11] = mk("rs2_miss",  5'd0,  5'd4,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, E_NONE);

    do_reset();

    // Table-driven single-cycle vectors; counter expectations tallied from the table
    exp_stall = 0; exp_flush = 0; exp_lu = 0;
    foreach (tbl[i]) begin
      step(tbl[i]);
      exp_stall += int'(tbl[i].exp[6]);
      exp_flush += int'(tbl[i].exp[2]);
      exp_lu    += int'(tbl[i].exp[6] & ~tbl[i].exp[3]);
    end
    @(posedge clk); #1;
    chk("tbl_stall_cycles", 32'(bus.stall_cycles), 32'(exp_stall));
    chk("tbl_flush_count", 32'(bus.flush_count), 32'(exp_flush));
    chk("tbl_load_use_count", 32'(bus.load_use_count), 32'(exp_lu));

    // Three wait cycles, release on the fourth
    do_reset();
    memw = mk("mem_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM);
    for (int i = 0; i < 3; i++) step(memw);
    step(mk("mem_release", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
    step(idle);
    chk("wait3_stall_cycles", 32'(bus.stall_cycles), 32'd3);
    chk("wait3_flush_count", 32'(bus.flush_count), 32'd0);

    // Timeout, clr_err losing to a live set, counter saturation, then a clear
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.clr_err = (i == 10);
      step(memw);
      if (i == 3)  chk("tmo_early", 32'(bus.mem_timeout), 32'd0);
      if (i == 6)  chk("tmo_set", 32'(bus.mem_timeout), 32'd1);
      if (i == 11) chk("tmo_set_wins", 32'(bus.mem_timeout), 32'd1);
    end
    bus.clr_err = 1'b0;
    step(mk("tmo_release", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
    chk("stall_cycles_sat", 32'(bus.stall_cycles), 32'd15);
    chk("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
    bus.clr_err = 1'b1;
    step(idle);
    bus.clr_err = 1'b0;
    step(idle);
    chk("tmo_cleared", 32'(bus.mem_timeout), 32'd0);

    // Branch held across a two-cycle wait is acted on at release
    do_reset();
    memw_br = mk("br_in_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_MEM);
    rel_br  = mk("br_release", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_BR);
    step(memw_br);
    step(memw_br);
    step(rel_br);
    step(idle);
    chk("br_wait_flush_count", 32'(bus.flush_count), 32'd1);
    chk("br_wait_stall_cycles", 32'(bus.stall_cycles), 32'd2);

    // Reset asserted mid-wait clears outputs and counters without a clock edge
    step(memw);
    step(memw);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'(ctrl_out()), 32'(E_NONE));
    chk("midrst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("midrst_flush_count", 32'(bus.flush_count), 32'd0);
    @(negedge clk);
    apply(idle);
    #1 rst_n = 1'b1;
    sample();
    // Back in RUN: a zero-wait access causes no stall
    step(mk("post_rst_zero_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE));
    step(idle);
    chk("post_rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline; it is the companion to the EX-stage forwarding unit.
- The forwarding unit resolves RAW hazards by bypass. This block handles the hazards bypass cannot cover: load-use, taken-branch redirect, and data-memory wait states.
- It drives hold enables and bubble/flush controls to PC, IfId, IdEx, ExMem and MemWB.
- It also keeps a memory-wait timeout monitor and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 64: MEM_WAIT cycles before the mem_timeout error is set.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1_IfId  in  5  rs1 of instruction in ID
- rs2_IfId  in  5  rs2 of instruction in ID
- use_rs1_IfId  in  1  ID instruction actually reads rs1
- use_rs2_IfId  in  1  ID instruction actually reads rs2
- rd_IdEx  in  5  rd of instruction in EX
- mem_read_IdEx  in  1  EX instruction is a load
- branch_taken_Ex  in  1  EX resolved a taken branch/jump (redirect)
- dmem_req_ExMem  in  1  MEM-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- clr_err  in  1  clears mem_timeout
- stall_pc  out  1  hold PC
- stall_IfId  out  1  hold IfId register
- stall_IdEx  out  1  hold IdEx register
- stall_ExMem  out  1  hold ExMem register
- flush_IfId  out  1  load NOP into IfId
- bubble_IdEx  out  1  load NOP into IdEx
- bubble_MemWB  out  1  load NOP into MemWB
- mem_timeout  out  1  sticky error
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1
- flush_count  out  CNT_W  count of taken-branch flushes
- load_use_count  out  CNT_W  count of load-use bubbles

Behaviour:

State machine (registered): RUN, MEM_WAIT; wait_cnt is $clog2(MEM_TIMEOUT+1) bits.

Condition definitions (combinational):
- mem_stall = dmem_req_ExMem & ~dmem_ready (evaluated in both states).
- load_use = mem_read_IdEx & (rd_IdEx != 0) & ((use_rs1_IfId & rs1_IfId == rd_IdEx) | (use_rs2_IfId & rs2_IfId == rd_IdEx)).

Outputs are combinational from state and inputs; the first match in priority order applies:
1. mem_stall:
   - stall_pc = stall_IfId = stall_IdEx = stall_ExMem = 1, bubble_MemWB = 1.
   - flush and load-use requests are ignored.
   - EX is frozen, so branch_taken_Ex persists and is acted on in the release cycle.
2. branch_taken_Ex:
   - flush_IfId = 1, bubble_IdEx = 1, no stalls.
   - Any simultaneous load_use is on the wrong path and is discarded; load_use_count does not increment.
3. load_use:
   - stall_pc = stall_IfId = 1, bubble_IdEx = 1.
   - Exactly one bubble results, because the next cycle IdEx holds a NOP (mem_read_IdEx = 0).
4. Otherwise: all control outputs are 0.

Transitions and counters:
- RUN -> MEM_WAIT when mem_stall; wait_cnt <= 1.
- MEM_WAIT -> RUN on the cycle dmem_ready = 1. That cycle has no mem stall; priorities 2–4 apply.
- In MEM_WAIT with !dmem_ready: wait_cnt increments, saturating at MEM_TIMEOUT.
- When wait_cnt == MEM_TIMEOUT and still waiting: mem_timeout <= 1. The pipeline stays stalled; there is no forced release.
- A request completing with zero wait (dmem_req & dmem_ready in RUN) causes no stall and no state change.
- If dmem_req_ExMem drops while in MEM_WAIT (which should not happen), treat it as release: go to RUN.
- mem_timeout: cleared by clr_err the cycle after assertion. If clr_err and a new set occur in the same cycle, the set wins.
- Perf counters increment on their event and saturate at all-ones; there is no wrap.

Reset:
- While rst_n = 0, all outputs are 0 (the combinational outputs are gated by rst_n).
- State = RUN, wait_cnt = 0, counters = 0, mem_timeout = 0.
- Reset asserted mid-MEM_WAIT returns to RUN immediately, without waiting for a clock edge.

Test Plan:
- Load-use: mem_read_IdEx=1, rd_IdEx=5, rs2_IfId=5, use_rs2_IfId=1 -> one cycle of stall_pc=stall_IfId=bubble_IdEx=1, then all 0; load_use_count=1.
- rd_IdEx=0 with matching rs1=0, or use_rs1_IfId=0 with rs1=rd -> no stall, counters unchanged.
- Branch and load-use in the same cycle -> flush_IfId=bubble_IdEx=1, stall_pc=0; flush_count=1, load_use_count=0.
- dmem_req_ExMem=1 with dmem_ready low for 3 cycles then high -> 3 cycles of all stalls plus bubble_MemWB; release on cycle 4; stall_cycles=3; state returns to RUN.
- MEM_TIMEOUT=4, dmem_ready held low -> mem_timeout=1 after the 4th wait cycle with the stall maintained; clr_err pulse -> 0 next cycle.
- branch_taken_Ex=1 during a 2-cycle mem wait -> no flush during the wait, flush on the release cycle; rst_n pulsed low mid-wait -> outputs 0 immediately, counters 0, state RUN.
